// File: rtl/alu_exec_seq.sv
// EX-stage ALU: single-cycle logic/arith/compare ops, iterative one-bit-per-cycle shifts,
// valid/ready handshake on both request and result sides.
module alu_exec_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [3:0]             ALU_OP_i,
    input  logic [DATA_WIDTH-1:0]  SRC_A_i,
    input  logic [DATA_WIDTH-1:0]  SRC_B_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_WIDTH-1:0]  RESULT_o,
    output logic                   ZERO_o
);

    localparam logic [3:0] OP_AND    = 4'b0000;
    localparam logic [3:0] OP_OR     = 4'b0001;
    localparam logic [3:0] OP_SUM    = 4'b0010;
    localparam logic [3:0] OP_EQUAL  = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRL    = 4'b0101;
    localparam logic [3:0] OP_SRA    = 4'b0111;
    localparam logic [3:0] OP_XOR    = 4'b1000;
    localparam logic [3:0] OP_NOR    = 4'b1001;
    localparam logic [3:0] OP_SUB    = 4'b1010;
    localparam logic [3:0] OP_GE     = 4'b1100;
    localparam logic [3:0] OP_GE_U   = 4'b1101;
    localparam logic [3:0] OP_SLT    = 4'b1110;
    localparam logic [3:0] OP_SLT_U  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [DATA_WIDTH-1:0]   r_work;
    logic [SHAMT_WIDTH-1:0]  r_cnt;
    logic [3:0]              r_op;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_zero;

    logic [DATA_WIDTH-1:0]   w_alu_res;
    logic [DATA_WIDTH-1:0]   w_shift_next;
    logic [SHAMT_WIDTH-1:0]  w_shamt;
    logic                    w_is_shift;
    logic                    w_accept;
    logic                    w_last_shift;

    assign w_shamt      = SRC_B_i[SHAMT_WIDTH-1:0];
    assign w_is_shift   = (ALU_OP_i == OP_SLL) || (ALU_OP_i == OP_SRL) || (ALU_OP_i == OP_SRA);
    assign w_accept     = (r_state == ST_IDLE) && in_valid_i;
    assign w_last_shift = (r_state == ST_SHIFT) && (r_cnt == SHAMT_WIDTH'(1));

    assign in_ready_o  = (r_state == ST_IDLE);
    assign out_valid_o = (r_state == ST_DONE);
    assign RESULT_o    = r_result;
    assign ZERO_o      = r_zero;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_alu_res = '0;
        case (ALU_OP_i)
            OP_AND:   w_alu_res = SRC_A_i & SRC_B_i;
            OP_OR:    w_alu_res = SRC_A_i | SRC_B_i;
            OP_SUM:   w_alu_res = SRC_A_i + SRC_B_i;
            OP_SUB:   w_alu_res = SRC_A_i - SRC_B_i;
            OP_XOR:   w_alu_res = SRC_A_i ^ SRC_B_i;
            OP_NOR:   w_alu_res = ~(SRC_A_i | SRC_B_i);
            OP_EQUAL: w_alu_res[0] = (SRC_A_i == SRC_B_i);
            OP_GE:    w_alu_res[0] = ($signed(SRC_A_i) >= $signed(SRC_B_i));
            OP_GE_U:  w_alu_res[0] = (SRC_A_i >= SRC_B_i);
            OP_SLT:   w_alu_res[0] = ($signed(SRC_A_i) < $signed(SRC_B_i));
            OP_SLT_U: w_alu_res[0] = (SRC_A_i < SRC_B_i);
            default:  w_alu_res = '0;
        endcase
    end

    // One-bit step of the latched shift kind; operand inputs are not consulted here.
    always_comb begin
        w_shift_next = r_work;
        case (r_op)
            OP_SLL:  w_shift_next = {r_work[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  w_shift_next = {1'b0, r_work[DATA_WIDTH-1:1]};
            default: w_shift_next = {r_work[DATA_WIDTH-1], r_work[DATA_WIDTH-1:1]};
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid_i) begin
                    if (w_is_shift && (w_shamt != '0)) w_state_next = ST_SHIFT;
                    else                              w_state_next = ST_DONE;
                end
            end
            ST_SHIFT: if (r_cnt == SHAMT_WIDTH'(1)) w_state_next = ST_DONE;
            ST_DONE:  if (out_ready_i)              w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: all datapath registers are reset so a flushed shift leaves no stale operand behind.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_work   <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else if (w_accept) begin
            if (w_is_shift) begin
                r_work <= SRC_A_i;
                r_cnt  <= w_shamt;
                r_op   <= ALU_OP_i;
                if (w_shamt == '0) begin
                    r_result <= SRC_A_i;
                    r_zero   <= (SRC_A_i == '0);
                end
            end else begin
                r_result <= w_alu_res;
                r_zero   <= (w_alu_res == '0);
            end
        end else if (r_state == ST_SHIFT) begin
            r_work <= w_shift_next;
            r_cnt  <= r_cnt - SHAMT_WIDTH'(1);
            if (w_last_shift) begin
                r_result <= w_shift_next;
                r_zero   <= (w_shift_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: directed test-plan steps plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_exec_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  ALU_OP_i;
    logic [31:0] SRC_A_i;
    logic [31:0] SRC_B_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] RESULT_o;
    logic        ZERO_o;

    int checks   = 0;
    int failures = 0;

    alu_exec_seq #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .ALU_OP_i    (ALU_OP_i),
        .SRC_A_i     (SRC_A_i),
        .SRC_B_i     (SRC_B_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .RESULT_o    (RESULT_o),
        .ZERO_o      (ZERO_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b1010: return a - b;
            4'b0011: return (a == b) ? 32'd1 : 32'd0;
            4'b1100: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            4'b1101: return (a >= b) ? 32'd1 : 32'd0;
            4'b1110: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1111: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a << sh;
            4'b0101: return a >> sh;
            4'b0111: return $unsigned($signed(a) >>> sh);
            4'b1000: return a ^ b;
            4'b1001: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
        if ((op == 4'b0100 || op == 4'b0101 || op == 4'b0111) && (b % 32) != 0)
            return int'(b % 32) + 1;
        return 1;
    endfunction

    // Starts at a negedge with the DUT idle; leaves it idle at a negedge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string tag);
        logic [31:0] exp;
        int          lat;
        exp = ref_alu(op, a, b);
        check({31'b0, in_ready_o}, 32'd1, {tag, ".ready_before"});
        in_valid_i = 1'b1;
        ALU_OP_i   = op;
        SRC_A_i    = a;
        SRC_B_i    = b;
        @(posedge clk_i);
        @(negedge clk_i);
        lat = 1;
        ALU_OP_i = 4'($urandom);
        SRC_A_i  = $urandom;
        SRC_B_i  = $urandom;
        while (out_valid_o !== 1'b1 && lat < 64) begin
            @(negedge clk_i);
            lat++;
            ALU_OP_i = 4'($urandom);
            SRC_A_i  = $urandom;
            SRC_B_i  = $urandom;
        end
        check(32'(lat), 32'(ref_latency(op, b)), {tag, ".latency"});
        check(RESULT_o, exp, {tag, ".result"});
        check({31'b0, ZERO_o}, {31'b0, exp == 32'd0}, {tag, ".zero"});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk_i);
            SRC_A_i = $urandom;
            SRC_B_i = $urandom;
            check(RESULT_o, exp, {tag, ".hold_result"});
            check({30'b0, out_valid_o, in_ready_o}, 32'd2, {tag, ".hold_valid_ready"});
        end
        out_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;
        check({30'b0, out_valid_o, in_ready_o}, 32'd1, {tag, ".back_to_idle"});
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        ALU_OP_i    = 4'd0;
        SRC_A_i     = 32'd0;
        SRC_B_i     = 32'd0;
        @(posedge clk_i);
        @(negedge clk_i);
        check({31'b0, out_valid_o}, 32'd0, "reset.out_valid");
        check(RESULT_o, 32'd0, "reset.result");
        check({31'b0, ZERO_o}, 32'd1, "reset.zero");
        check({31'b0, in_ready_o}, 32'd1, "reset.in_ready");
        rst_i = 1'b0;
        @(negedge clk_i);

        run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 0, "sum_wrap");
        check(ref_alu(4'b0010, 32'hFFFF_FFFF, 32'd1), 32'd0, "model.sum_wrap");
        run_op(4'b1010, 32'd5, 32'd7, 0, "sub_neg");

        run_op(4'b1110, 32'hFFFF_FFFF, 32'd1, 0, "slt");
        run_op(4'b1111, 32'hFFFF_FFFF, 32'd1, 0, "slt_u");
        run_op(4'b1100, 32'hFFFF_FFFF, 32'd1, 0, "ge");
        run_op(4'b1101, 32'hFFFF_FFFF, 32'd1, 0, "ge_u");
        run_op(4'b0011, 32'h1234, 32'h1234, 0, "equal");

        run_op(4'b0111, 32'h8000_0010, 32'd4, 0, "sra4");
        run_op(4'b0101, 32'h8000_0010, 32'd4, 0, "srl4");
        run_op(4'b0100, 32'h8000_0010, 32'h21, 0, "sll_shamt1");
        run_op(4'b0101, 32'h8000_0010, 32'd0, 0, "shift0");
        run_op(4'b0111, 32'h8000_0000, 32'd31, 0, "sra31");

        run_op(4'b0001, 32'h0F0F_0000, 32'h0000_00F0, 3, "hold3");

        // Reset in the middle of a 20-bit left shift.
        check({31'b0, in_ready_o}, 32'd1, "rst_mid.ready_before");
        in_valid_i = 1'b1;
        ALU_OP_i   = 4'b0100;
        SRC_A_i    = 32'h8000_0010;
        SRC_B_i    = 32'd20;
        @(posedge clk_i);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check({31'b0, out_valid_o}, 32'd0, "rst_mid.out_valid");
        check(RESULT_o, 32'd0, "rst_mid.result");
        check({31'b0, ZERO_o}, 32'd1, "rst_mid.zero");
        check({31'b0, in_ready_o}, 32'd1, "rst_mid.in_ready");
        run_op(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 0, "and_after_rst");

        run_op(4'b1001, 32'd0, 32'd0, 0, "nor");
        run_op(4'b1000, 32'hAAAA_5555, 32'hFFFF_FFFF, 0, "xor");
        run_op(4'b0110, 32'h1234_5678, 32'h9ABC_DEF0, 0, "unused_0110");
        run_op(4'b1011, 32'h1234_5678, 32'h9ABC_DEF0, 0, "unused_1011");

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom);
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) b = b & 32'hFFFF_FF07;
            run_op(op, a, b, $urandom_range(0, 2), $sformatf("rand%0d_op%0h", i, op));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
